// File: rtl/mult_arb_pkg.sv
// mult_arbiter shared types: FSM state encoding and matrix type.
// Default sizes match the 4x4 Q-format multiplier in the Kalman datapath.
package mult_arb_pkg;

  localparam int MA_WIDTH = 16;
  localparam int MA_NOS   = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    WAIT  = ST_WAIT,
    DONE  = ST_DONE
  } arb_state_t;

  typedef logic [MA_NOS-1:0][MA_NOS-1:0][MA_WIDTH-1:0] mat_t;

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester bus plus multiplier bus seen by mult_arbiter.
// slave = arbiter side, master = requesters and multiplier.
interface mult_arbiter_if
  import mult_arb_pkg::*;
#(
  parameter int WIDTH = MA_WIDTH,
  parameter int nos   = MA_NOS,
  parameter int NREQ  = 3
);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;
  logic [NREQ-1:0][nos-1:0][nos-1:0][WIDTH-1:0] reqA;
  logic [NREQ-1:0][nos-1:0][nos-1:0][WIDTH-1:0] reqB;
  logic [nos-1:0][nos-1:0][WIDTH-1:0] Res;
  logic [nos-1:0][nos-1:0][WIDTH-1:0] m_A;
  logic [nos-1:0][nos-1:0][WIDTH-1:0] m_B;
  logic [nos-1:0][nos-1:0][WIDTH-1:0] m_Res;
  logic busy;
  logic m_start;
  logic m_end;

  modport slave (
    input  req, reqA, reqB, m_Res, m_end,
    output gnt, done, Res, busy, m_start, m_A, m_B
  );

  modport master (
    output req, reqA, reqB, m_Res, m_end,
    input  gnt, done, Res, busy, m_start, m_A, m_B
  );

endinterface

// File: rtl/mult_arbiter_rr_picker.sv
// rr_picker: combinational one-hot winner select for mult_arbiter.
// MULT_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
module rr_picker #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] last_i,
  output logic [NREQ-1:0]         win_o,
  output logic                    any_o
);

  assign any_o = |req_i;

`ifdef MULT_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last_i;

  always_comb begin
    win_o = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        win_o    = '0;
        win_o[i] = 1'b1;
      end
    end
  end
`else
  logic [$clog2(NREQ)-1:0] idx;

  // Walk from farthest to nearest so the nearest hit after last wins.
  always_comb begin
    win_o = '0;
    idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = $clog2(NREQ)'((int'(last_i) + k) % NREQ);
      if (req_i[idx]) begin
        win_o      = '0;
        win_o[idx] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one NxN matrix multiplier between NREQ requesters.
// Round-robin by default; MULT_ARB_FIXED_PRIO_EN gives fixed priority.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int WIDTH = MA_WIDTH,
  parameter int nos   = MA_NOS,
  parameter int NREQ  = 3
) (
  input logic           clk,
  input logic           rst,
  input logic           clk_en,
  mult_arbiter_if.slave bus
);

  localparam int IW = $clog2(NREQ);

  typedef logic [nos-1:0][nos-1:0][WIDTH-1:0] mat_l_t;

  arb_state_t      state_q;
  logic [IW-1:0]   last_q;
  logic [IW-1:0]   win_idx;
  logic [NREQ-1:0] win;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  logic            any;
  logic            start_q;
  logic            busy_q;
  mat_l_t          a_q;
  mat_l_t          b_q;
  mat_l_t          res_q;
  mat_l_t          a_sel;
  mat_l_t          b_sel;

  rr_picker #(
    .NREQ (NREQ)
  ) u_pick (
    .req_i  (bus.req),
    .last_i (last_q),
    .win_o  (win),
    .any_o  (any)
  );

  always_comb begin
    win_idx = '0;
    a_sel   = '0;
    b_sel   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) begin
        win_idx = IW'(i);
        a_sel   = bus.reqA[i];
        b_sel   = bus.reqB[i];
      end
    end
  end

  // Operands are captured at grant so requesters may move on afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IW'(NREQ - 1);
      gnt_q   <= '0;
      done_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else if (clk_en) begin
      done_q  <= '0;
      start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any) begin
            gnt_q   <= win;
            last_q  <= win_idx;
            a_q     <= a_sel;
            b_q     <= b_sel;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: state_q <= WAIT;
        WAIT: begin
          if (bus.m_end) begin
            res_q   <= bus.m_Res;
            done_q  <= gnt_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.Res     = res_q;
  assign bus.busy    = busy_q;
  assign bus.m_start = start_q;
  assign bus.m_A     = a_q;
  assign bus.m_B     = b_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed bench with a behavioural Q8.8 multiplier.
// Scoreboard queue holds expected done/Res per job.
module tb_mult_arbiter;
  import mult_arb_pkg::*;

  localparam int NREQ = 3;
  localparam int NOS  = MA_NOS;
  localparam int QF   = 8;

  typedef struct {
    logic [NREQ-1:0] who;
    mat_t            res;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic clk_en;
  logic mrst;
  logic [2:0] mcnt;
  int checks = 0;
  int failures = 0;
  int n_done = 0;
  int n_push = 0;
  exp_t sbq[$];
  int ct_idx [4];

  always #5 clk = ~clk;

  mult_arbiter_if #(
    .WIDTH (MA_WIDTH),
    .nos   (NOS),
    .NREQ  (NREQ)
  ) bus ();

  mult_arbiter #(
    .WIDTH (MA_WIDTH),
    .nos   (NOS),
    .NREQ  (NREQ)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .bus    (bus)
  );

  function automatic mat_t matmul(input mat_t a, input mat_t b);
    mat_t r;
    logic signed [39:0] acc;
    logic signed [31:0] p;
    r = '0;
    for (int i = 0; i < NOS; i++) begin
      for (int j = 0; j < NOS; j++) begin
        acc = '0;
        for (int k = 0; k < NOS; k++) begin
          p = 32'($signed(a[i][k])) * 32'($signed(b[k][j]));
          acc = acc + 40'(p);
        end
        r[i][j] = acc[QF +: MA_WIDTH];
      end
    end
    return r;
  endfunction

  function automatic mat_t ident(input logic [MA_WIDTH-1:0] s);
    mat_t r;
    r = '0;
    for (int i = 0; i < NOS; i++) r[i][i] = s;
    return r;
  endfunction

  function automatic mat_t seqm(input int base);
    mat_t r;
    for (int i = 0; i < NOS; i++)
      for (int j = 0; j < NOS; j++)
        r[i][j] = MA_WIDTH'((base + i * NOS + j) << QF);
    return r;
  endfunction

  // Multiplier: ends nos+1 enabled cycles after sampling start.
  always @(posedge clk) begin
    if (mrst) begin
      mcnt      <= '0;
      bus.m_end <= 1'b0;
      bus.m_Res <= '0;
    end else if (clk_en) begin
      bus.m_end <= 1'b0;
      if (bus.m_start) begin
        mcnt      <= 3'(NOS + 1);
        bus.m_Res <= matmul(bus.m_A, bus.m_B);
      end else if (mcnt == 3'd1) begin
        mcnt      <= '0;
        bus.m_end <= 1'b1;
      end else if (mcnt != '0) begin
        mcnt <= mcnt - 3'd1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic mchk(input string tag, input mat_t obs, input mat_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [NREQ-1:0] who, input mat_t a,
                      input mat_t b);
    exp_t e;
    e.who = who;
    e.res = matmul(a, b);
    sbq.push_back(e);
    n_push++;
  endtask

  task automatic do_reset(input logic en);
    clk_en  = en;
    rst     = 1'b1;
    bus.req = '0;
    step(2);
    rst    = 1'b0;
    clk_en = 1'b1;
  endtask

  task automatic monitor();
    logic [NREQ-1:0] prev;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      if ((|bus.done) === 1'b1 && prev === '0) begin
        n_done++;
        checks++;
        assert (sbq.size() != 0) else begin
          failures++;
          $error("FAIL sb_unexpected_done obs=%b exp=none", bus.done);
        end
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          checks++;
          assert (bus.done === e.who) else begin
            failures++;
            $error("FAIL sb_done obs=%b exp=%b", bus.done, e.who);
          end
          checks++;
          assert (bus.Res === e.res) else begin
            failures++;
            $error("FAIL sb_res obs=%h exp=%h", bus.Res, e.res);
          end
        end
      end
      prev = bus.done;
    end
  endtask

  initial begin
    rst      = 1'b1;
    clk_en   = 1'b0;
    mrst     = 1'b1;
    bus.req  = '0;
    bus.reqA = '0;
    bus.reqB = '0;
`ifdef MULT_ARB_FIXED_PRIO_EN
    ct_idx = '{0, 0, 0, 0};
`else
    ct_idx = '{0, 1, 2, 0};
`endif
    fork
      monitor();
    join_none

    // Reset with clk_en low
    step(2);
    mrst = 1'b0;
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_start", 32'(bus.m_start), 0);
    mchk("rst_mA", bus.m_A, '0);
    mchk("rst_mB", bus.m_B, '0);
    mchk("rst_Res", bus.Res, '0);
    rst    = 1'b0;
    clk_en = 1'b1;

    // Single request plus operand change after grant
    bus.reqA[0] = ident(16'h0100);
    bus.reqB[0] = seqm(1);
    bus.req     = 3'b001;
    push(3'b001, ident(16'h0100), seqm(1));
    step(1);
    chk("t1_gnt", 32'(bus.gnt), 32'h1);
    chk("t1_start", 32'(bus.m_start), 1);
    chk("t1_busy", 32'(bus.busy), 1);
    mchk("t1_mA", bus.m_A, ident(16'h0100));
    bus.reqA[0] = ident(16'h0300);
    step(1);
    chk("t1_start_lo", 32'(bus.m_start), 0);
    mchk("t1_mA_hold", bus.m_A, ident(16'h0100));
    step(5);
    chk("t1_pre_done", 32'(bus.done), 0);
    step(1);
    chk("t1_done", 32'(bus.done), 32'h1);
    mchk("t1_res", bus.Res, seqm(1));
    bus.req = '0;
    step(1);
    chk("t1_gnt_clr", 32'(bus.gnt), 0);
    chk("t1_busy_clr", 32'(bus.busy), 0);
    step(2);
    chk("t1_idle", 32'(bus.busy), 0);

    // Contention, all three requesting
    do_reset(1'b1);
    bus.reqA[0] = ident(16'h0100);
    bus.reqB[0] = seqm(1);
    bus.reqA[1] = ident(16'h0200);
    bus.reqB[1] = seqm(17);
    bus.reqA[2] = ident(16'hFF00);
    bus.reqB[2] = seqm(33);
    bus.req     = 3'b111;
    for (int k = 0; k < 4; k++)
      push(NREQ'(1) << ct_idx[k], bus.reqA[ct_idx[k]], bus.reqB[ct_idx[k]]);
    step(1);
    for (int k = 0; k < 4; k++) begin
      chk("ct_gnt", 32'(bus.gnt), 32'(1) << ct_idx[k]);
      step(7);
      chk("ct_done", 32'(bus.done), 32'(1) << ct_idx[k]);
      if (k == 3) bus.req = '0;
      else step(2);
    end
    step(3);
    chk("ct_idle", 32'(bus.busy), 0);

    // Stall during START and WAIT, then hold done frozen
    do_reset(1'b1);
    bus.reqA[0] = ident(16'h0080);
    bus.reqB[0] = seqm(2);
    bus.req     = 3'b001;
    push(3'b001, ident(16'h0080), seqm(2));
    step(1);
    chk("st_start", 32'(bus.m_start), 1);
    clk_en = 1'b0;
    step(2);
    chk("st_start_hold", 32'(bus.m_start), 1);
    chk("st_gnt_hold", 32'(bus.gnt), 32'h1);
    clk_en = 1'b1;
    step(1);
    chk("st_start_lo", 32'(bus.m_start), 0);
    step(1);
    clk_en = 1'b0;
    step(5);
    chk("st_frz_nodone", 32'(bus.done), 0);
    clk_en = 1'b1;
    step(4);
    chk("st_pre_done", 32'(bus.done), 0);
    step(1);
    chk("st_done", 32'(bus.done), 32'h1);
    clk_en = 1'b0;
    step(3);
    chk("st_done_hold", 32'(bus.done), 32'h1);
    clk_en  = 1'b1;
    bus.req = '0;
    step(1);
    chk("st_done_clr", 32'(bus.done), 0);
    chk("st_gnt_clr", 32'(bus.gnt), 0);

    // Reset mid-job, late m_end must be ignored
    do_reset(1'b1);
    bus.reqA[0] = ident(16'h0100);
    bus.reqB[0] = seqm(3);
    bus.req     = 3'b001;
    step(1);
    chk("rm_gnt", 32'(bus.gnt), 32'h1);
    step(2);
    rst     = 1'b1;
    bus.req = '0;
    step(1);
    chk("rm_gnt_clr", 32'(bus.gnt), 0);
    chk("rm_busy_clr", 32'(bus.busy), 0);
    chk("rm_start_clr", 32'(bus.m_start), 0);
    rst = 1'b0;
    step(3);
    bus.reqA[1] = ident(16'h0100);
    bus.reqB[1] = seqm(5);
    bus.req     = 3'b010;
    push(3'b010, ident(16'h0100), seqm(5));
    step(1);
    chk("rm_gnt2", 32'(bus.gnt), 32'h2);
    step(7);
    chk("rm_done2", 32'(bus.done), 32'h2);
    bus.req = '0;
    step(2);
    chk("rm_idle", 32'(bus.busy), 0);

    // Request dropped after grant
    do_reset(1'b1);
    bus.reqA[2] = ident(16'h0100);
    bus.reqB[2] = seqm(9);
    bus.req     = 3'b100;
    push(3'b100, ident(16'h0100), seqm(9));
    step(1);
    chk("rd_gnt", 32'(bus.gnt), 32'h4);
    step(1);
    bus.req     = '0;
    bus.reqB[2] = seqm(40);
    step(6);
    chk("rd_done", 32'(bus.done), 32'h4);
    chk("rd_gnt_hold", 32'(bus.gnt), 32'h4);
    step(1);
    chk("rd_gnt_clr", 32'(bus.gnt), 0);
    step(5);
    chk("rd_idle_busy", 32'(bus.busy), 0);
    chk("rd_idle_gnt", 32'(bus.gnt), 0);

    step(2);
    chk("n_done", 32'(n_done), 32'(n_push));
    chk("sb_empty", 32'(sbq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
